// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared constants and the FSM state encoding for the PWM duty sequencer.
//   DUTY_W    : duty width, equal to the pwm_generator duty_cycle width
//   FRAME_LEN : clocks per PWM frame (2**DUTY_W)
//   state_t   : sequencer FSM states
package pwm_pkg;

    localparam int DUTY_W    = 4;
    localparam int FRAME_LEN = 2 ** DUTY_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RAMP  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Request/grant bundle between the duty requesters and the sequencer.
//   req      : per-requester duty-change request
//   req_duty : requested duty, requester i uses [i*DUTY_W +: DUTY_W]
//   grant    : one-hot, single-cycle acceptance pulse
//
// Handshake: a requester raises req[i] with req_duty slice i and holds both
// stable until it sees grant[i] high for one cycle, then drops req[i]. The
// transfer completes in the cycle grant[i] is high. A req[i] still high one
// cycle after its grant is a brand-new request.
interface pwm_duty_sequencer_if #(
    parameter int NUM_REQ = 3,
    parameter int DUTY_W  = pwm_pkg::DUTY_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DUTY_W-1:0] req_duty;
    logic [NUM_REQ-1:0]        grant;

    modport master (output req, output req_duty, input grant);
    modport slave  (input req, input req_duty, output grant);
endinterface

// File: rtl/pwm_duty_sequencer_rr_arbiter.sv
// Round-robin priority select: picks the first set request bit at or after
// the pointer, searching upward and wrapping.
//   i_req    : request vector
//   i_ptr    : highest-priority index
//   o_valid  : any request set
//   o_sel    : index of the selected request
//   o_onehot : one-hot form of o_sel (zero when nothing is selected)
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [PTR_W-1:0]   o_sel,
    output logic [NUM_REQ-1:0] o_onehot
);
    int w_idx;

    // Scan from the farthest position back to the pointer so that the
    // closest set bit (offset 0 first) is the last one written and wins.
    always_comb begin
        o_valid  = 1'b0;
        o_sel    = '0;
        o_onehot = '0;
        w_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_sel    = PTR_W'(w_idx);
                o_onehot = NUM_REQ'(1) << w_idx;
            end
        end
    end
endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty sequencer in front of pwm_generator. Shares one PWM channel between
// NUM_REQ requesters (round robin), applies duty changes only at PWM frame
// wraps and ramps one count per frame toward the granted target.
//   clk_3125KHz : system clock (same as pwm_generator)
//   rst_n       : asynchronous active-low reset
//   bus         : req / req_duty in, grant out
//   duty_cycle  : duty currently applied, to pwm_generator.duty_cycle
//   target_duty : latched target of the active ramp
//   frame_start : high during the cycle frame_cnt == 0
//   busy        : high while ramping (state RAMP)
//   dbg_state   : current FSM state
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                clk_3125KHz,
    input  logic                rst_n,
    pwm_duty_sequencer_if.slave bus,
    output logic [DUTY_W-1:0]   duty_cycle,
    output logic [DUTY_W-1:0]   target_duty,
    output logic                frame_start,
    output logic                busy,
    output state_t              dbg_state
);
    localparam int                PTR_W    = $clog2(NUM_REQ);
    localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(FRAME_LEN - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [DUTY_W-1:0]  r_frame_cnt;
    logic               r_run;
    logic               r_frame_start;
    logic [DUTY_W-1:0]  r_duty;
    logic [DUTY_W-1:0]  r_target;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_gnt_vec;
    logic               w_arb_valid;
    logic [PTR_W-1:0]   w_arb_sel;
    logic [NUM_REQ-1:0] w_arb_onehot;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [DUTY_W-1:0]  w_req_duty;
    logic [DUTY_W-1:0]  w_duty_step;
    logic               w_wrap;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_busy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req    (bus.req),
        .i_ptr    (r_rr_ptr),
        .o_valid  (w_arb_valid),
        .o_sel    (w_arb_sel),
        .o_onehot (w_arb_onehot)
    );

    assign w_req_duty = bus.req_duty[int'(w_arb_sel) * DUTY_W +: DUTY_W];
    assign w_ptr_next = (int'(r_sel) == NUM_REQ - 1) ? '0 : r_sel + PTR_W'(1);

    // Step toward the target; the compare picks the direction so 15+1 and
    // 0-1 are never formed.
    always_comb begin
        w_duty_step = r_duty;
        if (r_duty < r_target) begin
            w_duty_step = r_duty + DUTY_W'(1);
        end else if (r_duty > r_target) begin
            w_duty_step = r_duty - DUTY_W'(1);
        end
    end

    // Frame counter. The first edge after reset release only arms the
    // counter, so frame_cnt is still 0 (and frame_start high) for the first
    // full cycle after release; from then on it free-runs and wraps.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
        end else if (!r_run) begin
            r_run         <= 1'b1;
            r_frame_start <= 1'b1;
        end else begin
            r_frame_cnt   <= r_frame_cnt + DUTY_W'(1);
            r_frame_start <= (r_frame_cnt == LAST_CNT);
        end
    end

    // High on the edge where frame_cnt goes 15 -> 0.
    assign w_wrap = r_run && (r_frame_cnt == LAST_CNT);

    // FSM: state register
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                w_next_state = (r_target == r_duty) ? IDLE : RAMP;
            end
            RAMP: begin
                if (w_wrap && (w_duty_step == r_target)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_grant = '0;
        w_busy  = 1'b0;
        case (r_state)
            GRANT:   w_grant = r_gnt_vec;
            RAMP:    w_busy  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: request latch, round-robin pointer and duty stepping.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_target  <= '0;
            r_sel     <= '0;
            r_gnt_vec <= '0;
            r_rr_ptr  <= '0;
            r_duty    <= '0;
        end else begin
            if (r_state == IDLE && w_arb_valid) begin
                r_target  <= w_req_duty;
                r_sel     <= w_arb_sel;
                r_gnt_vec <= w_arb_onehot;
            end
            if (r_state == GRANT) begin
                r_rr_ptr <= w_ptr_next;
            end
            // Only RAMP steps, so a grant coinciding with a wrap skips that frame.
            if (r_state == RAMP && w_wrap) begin
                r_duty <= w_duty_step;
            end
        end
    end

    assign bus.grant   = w_grant;
    assign busy        = w_busy;
    assign duty_cycle  = r_duty;
    assign target_duty = r_target;
    assign frame_start = r_frame_start;
    assign dbg_state   = r_state;

endmodule
